// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcode constants, flag bit positions,
// branch condition codes, the buffered entry record and the branch condition evaluator.
package alu_pkg;

  localparam int unsigned AluDataW = 16;
  localparam int unsigned AluAddrW = 3;

  // ALU opcodes (S_ALU); AluNon never touches the flag register.
  localparam logic [3:0] AluAdd = 4'h0;
  localparam logic [3:0] AluSub = 4'h1;
  localparam logic [3:0] AluAnd = 4'h2;
  localparam logic [3:0] AluOr  = 4'h3;
  localparam logic [3:0] AluXor = 4'h4;
  localparam logic [3:0] AluNot = 4'h5;
  localparam logic [3:0] AluShl = 4'h6;
  localparam logic [3:0] AluShr = 4'h7;
  localparam logic [3:0] AluNon = 4'hF;

  // Flag register bit positions within {S,Z,C,V}.
  localparam int unsigned FlagS = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Branch condition codes.
  localparam logic [2:0] BrAl = 3'b000;
  localparam logic [2:0] BrEq = 3'b001;
  localparam logic [2:0] BrNe = 3'b010;
  localparam logic [2:0] BrLt = 3'b011;
  localparam logic [2:0] BrGe = 3'b100;
  localparam logic [2:0] BrLe = 3'b101;
  localparam logic [2:0] BrGt = 3'b110;
  localparam logic [2:0] BrCs = 3'b111;

  typedef struct packed {
    logic [AluDataW-1:0] data;
    logic [AluAddrW-1:0] addr;
    logic                we;
    logic                taken;
  } entry_t;

  function automatic logic br_eval(input logic [2:0] cond, input logic [3:0] flags);
    logic lt;
    logic res;
    lt = flags[FlagS] ^ flags[FlagV];
    case (cond)
      BrAl:    res = 1'b1;
      BrEq:    res = flags[FlagZ];
      BrNe:    res = ~flags[FlagZ];
      BrLt:    res = lt;
      BrGe:    res = ~lt;
      BrLe:    res = flags[FlagZ] | lt;
      BrGt:    res = ~flags[FlagZ] & ~lt;
      BrCs:    res = flags[FlagC];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Bus between the ALU/issue side, the result stage and the register file / PC stage.
// master: drives upstream entry fields and OUT_READY; slave: the result stage itself.
// Forwarding signals (fwd_*) exist only when FWD_BYPASS_EN is defined.
interface alu_result_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flag;
  logic [3:0]        s_alu;
  logic              flag_we;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_we;
  logic              br_en;
  logic [2:0]        br_cond;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;
  logic              br_taken;
  logic [3:0]        flags;
`ifdef FWD_BYPASS_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  modport master (
`ifdef FWD_BYPASS_EN
    input  fwd_valid, fwd_addr, fwd_data,
`endif
    output in_valid, alu_res, alu_flag, s_alu, flag_we, rd_addr, rd_we, br_en, br_cond,
    output out_ready,
    input  in_ready, out_valid, wb_data, wb_addr, wb_we, br_taken, flags
  );

  modport slave (
`ifdef FWD_BYPASS_EN
    output fwd_valid, fwd_addr, fwd_data,
`endif
    input  in_valid, alu_res, alu_flag, s_alu, flag_we, rd_addr, rd_we, br_en, br_cond,
    input  out_ready,
    output in_ready, out_valid, wb_data, wb_addr, wb_we, br_taken, flags
  );
endinterface

// File: rtl/result_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main + skid register), strictly FIFO.
// Ports: clk_i, rst_i (async, active-high); in_valid_i/in_ready_o/in_data_i upstream;
// out_valid_o/out_ready_i/out_data_o downstream; skid_valid_o/skid_data_o expose the
// younger (skid) entry for observers such as operand forwarding.
module result_skid_buf #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o,
  output logic skid_valid_o,
  output T     skid_data_o
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  T     main_q, main_d;
  T     skid_q, skid_d;
  logic accept, drain;

  // Ready depends only on registered state, so no combinational path from out_ready_i.
  assign accept = in_valid_i & ~skid_valid_q;
  assign drain  = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (drain) begin
      if (skid_valid_q) begin
        // Accept cannot happen here because ready is low while skid is full.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = in_data_i;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = in_data_i;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready_o   = ~skid_valid_q;
  assign out_valid_o  = main_valid_q;
  assign out_data_o   = main_q;
  assign skid_valid_o = skid_valid_q;
  assign skid_data_o  = skid_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute/writeback boundary after the 16-bit ALU. Buffers result, destination and branch
// decision in a 2-entry skid buffer and owns the {S,Z,C,V} flag register.
// Ports: clk_i, rst_i (async, active-high), bus_io (alu_result_stage_if.slave) carrying the
// upstream entry handshake, downstream writeback handshake, flags and optional forwarding.
// Optional feature: define FWD_BYPASS_EN to drive fwd_valid/fwd_addr/fwd_data with the
// youngest buffered entry that writes the register file.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = AluDataW,
  parameter int unsigned ADDR_W = AluAddrW
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_result_stage_if.slave bus_io
);

  logic   in_ready;
  logic   out_valid;
  logic   skid_valid;
  logic   accept;
  entry_t in_entry, out_entry, skid_entry;
  logic [3:0] flags_q, flags_d;

  assign accept = bus_io.in_valid & in_ready;

  // Taken is resolved against the flags as they stand before this entry's own update.
  always_comb begin
    in_entry.data  = bus_io.alu_res[DATA_W-1:0];
    in_entry.addr  = bus_io.rd_addr[ADDR_W-1:0];
    in_entry.we    = bus_io.rd_we;
    in_entry.taken = bus_io.br_en & br_eval(bus_io.br_cond, flags_q);
  end

  // Flags update on accept, so a branch accepted next cycle already sees them.
  always_comb begin
    flags_d = flags_q;
    if (accept && bus_io.flag_we && (bus_io.s_alu != AluNon)) begin
      flags_d = bus_io.alu_flag;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  result_skid_buf #(
    .T(entry_t)
  ) u_skid_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (bus_io.in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_entry),
    .out_valid_o  (out_valid),
    .out_ready_i  (bus_io.out_ready),
    .out_data_o   (out_entry),
    .skid_valid_o (skid_valid),
    .skid_data_o  (skid_entry)
  );

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid;
  assign bus_io.wb_data   = out_entry.data;
  assign bus_io.wb_addr   = out_entry.addr;
  assign bus_io.wb_we     = out_valid & out_entry.we;
  assign bus_io.br_taken  = out_valid & out_entry.taken;
  assign bus_io.flags     = flags_q;

`ifdef FWD_BYPASS_EN
  // Skid holds the younger entry, so it wins over main.
  always_comb begin
    bus_io.fwd_valid = 1'b0;
    bus_io.fwd_addr  = '0;
    bus_io.fwd_data  = '0;
    if (skid_valid && skid_entry.we) begin
      bus_io.fwd_valid = 1'b1;
      bus_io.fwd_addr  = skid_entry.addr;
      bus_io.fwd_data  = skid_entry.data;
    end else if (out_valid && out_entry.we) begin
      bus_io.fwd_valid = 1'b1;
      bus_io.fwd_addr  = out_entry.addr;
      bus_io.fwd_data  = out_entry.data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{skid_valid, skid_entry};
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: send() queues the hand-computed expected entry at
// accept time; a negedge monitor pops and compares whenever an entry drains.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_result_stage_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  alu_result_stage #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  entry_t      exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compare every drained entry against the scoreboard head.
  always @(negedge clk) begin
    entry_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got data %0h, expected no entry", bus.wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_data", 32'(bus.wb_data), 32'(e.data));
        check("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
        check("wb_we", 32'(bus.wb_we), 32'(e.we));
        check("br_taken", 32'(bus.br_taken), 32'(e.taken));
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.alu_res  = '0;
    bus.alu_flag = '0;
    bus.s_alu    = AluNon;
    bus.flag_we  = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_we    = 1'b0;
    bus.br_en    = 1'b0;
    bus.br_cond  = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
  task automatic send(input logic [15:0] d, input logic [2:0] a, input logic we,
                      input logic [3:0] op, input logic fwe, input logic [3:0] fl,
                      input logic ben, input logic [2:0] cond, input logic exp_taken);
    int     n;
    entry_t e;
    bus.in_valid = 1'b1;
    bus.alu_res  = d;
    bus.rd_addr  = a;
    bus.rd_we    = we;
    bus.s_alu    = op;
    bus.flag_we  = fwe;
    bus.alu_flag = fl;
    bus.br_en    = ben;
    bus.br_cond  = cond;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end else begin
      e.data  = d;
      e.addr  = a;
      e.we    = we;
      e.taken = exp_taken;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_wb_data", 32'(bus.wb_data), 32'd0);
    check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    check("rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("rst_br_taken", 32'(bus.br_taken), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Streaming: latency 1, one per cycle.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send(16'(i), 3'(i), 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
      check("stream_valid", 32'(bus.out_valid), 32'd1);
      check("stream_data", 32'(bus.wb_data), 32'(i));
    end
    idle();
    wait_drain();
    check("idle_wb_we", 32'(bus.wb_we), 32'd0);

    // Backpressure: skid fills, outputs hold, FIFO order.
    bus.out_ready = 1'b0;
    send(16'hA00A, 3'd1, 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    check("ready_after_a", 32'(bus.in_ready), 32'd1);
    send(16'hB00B, 3'd2, 1'b0, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    idle();
    check("ready_after_b", 32'(bus.in_ready), 32'd0);
    check("stall_data0", 32'(bus.wb_data), 32'hA00A);
    @(posedge clk); #1;
    check("stall_data1", 32'(bus.wb_data), 32'hA00A);
    check("stall_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    send(16'hC00C, 3'd4, 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    idle();
    wait_drain();

    // Flags and branches.
    send(16'h0010, 3'd1, 1'b1, AluAdd, 1'b1, 4'b0100, 1'b0, BrAl, 1'b0);
    check("flags_z", 32'(bus.flags), 32'b0100);
    send(16'h0020, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrEq, 1'b1);
    send(16'h0021, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrNe, 1'b0);
    // Branch sees old flags (Z=1) even though the same entry loads S.
    send(16'h0022, 3'd2, 1'b1, AluSub, 1'b1, 4'b1000, 1'b1, BrEq, 1'b1);
    check("flags_s", 32'(bus.flags), 32'b1000);
    send(16'h0023, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrEq, 1'b0);
    send(16'h0024, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrLt, 1'b1);
    send(16'h0025, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrGe, 1'b0);
    send(16'h0026, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrLe, 1'b1);
    send(16'h0027, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrGt, 1'b0);
    send(16'h0030, 3'd3, 1'b1, AluAdd, 1'b1, 4'b0010, 1'b0, BrAl, 1'b0);
    send(16'h0031, 3'd3, 1'b1, AluNon, 1'b1, 4'b1111, 1'b0, BrAl, 1'b0);
    check("flags_nop_hold", 32'(bus.flags), 32'b0010);
    send(16'h0032, 3'd3, 1'b1, AluAdd, 1'b0, 4'b1111, 1'b0, BrAl, 1'b0);
    check("flags_we0_hold", 32'(bus.flags), 32'b0010);
    send(16'h0033, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrCs, 1'b1);
    send(16'h0034, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrGt, 1'b1);
    send(16'h0035, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    send(16'h0036, 3'd0, 1'b0, AluAdd, 1'b0, 4'h0, 1'b1, BrAl, 1'b1);
    idle();
    wait_drain();

    // Reset with two entries buffered drops both.
    bus.out_ready = 1'b0;
    send(16'h1111, 3'd5, 1'b1, AluAdd, 1'b1, 4'b1001, 1'b0, BrAl, 1'b0);
    send(16'h2222, 3'd6, 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    idle();
    check("full_before_rst", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_flags", 32'(bus.flags), 32'd0);
    check("midrst_wb_we", 32'(bus.wb_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("postrst_wb_data", 32'(bus.wb_data), 32'd0);
    bus.out_ready = 1'b1;
    send(16'h0040, 3'd7, 1'b1, AluAdd, 1'b0, 4'h0, 1'b1, BrEq, 1'b0);
    idle();
    wait_drain();

`ifdef FWD_BYPASS_EN
    bus.out_ready = 1'b0;
    check("fwd_empty", 32'(bus.fwd_valid), 32'd0);
    send(16'hBEEF, 3'd3, 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    idle();
    check("fwd_valid", 32'(bus.fwd_valid), 32'd1);
    check("fwd_addr", 32'(bus.fwd_addr), 32'd3);
    check("fwd_data", 32'(bus.fwd_data), 32'hBEEF);
    send(16'h1234, 3'd5, 1'b0, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    idle();
    check("fwd_skip_nowe", 32'(bus.fwd_data), 32'hBEEF);
    send(16'h5678, 3'd6, 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    send(16'h9ABC, 3'd2, 1'b1, AluAdd, 1'b0, 4'h0, 1'b0, BrAl, 1'b0);
    idle();
    bus.out_ready = 1'b1;
    wait_drain();
    check("fwd_drained", 32'(bus.fwd_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
